barrelunshift_stream: RTL and testbench
=======================================

// Module: barrelunshift_stream
// PURPOSE
// - Receive-side inverse of the multi-word barrel rotator. Accepts a stream of n_word-word frames whose
//   word boundary is offset by a known rotation; realigns across frame boundaries; emits aligned frames.
// - Sits between the ADC lane capture and the downstream sample FIFO. Registered output; valid/ready both sides.
// PARAMETERS
// - bit_shift  3               width of offset; offsets 0..n_word-1
// - n_word     2**bit_shift    words per frame
// - word_size  9               bits per word
// PORTS
// - clk        in   1                        single clock, rising edge
// - rst_n      in   1                        asynchronous, active-low reset
// - sh_load    in   1                        load new offset, flush history
// - sh_val     in   bit_shift                offset captured when sh_load=1
// - in         in   [word_size-1:0][n_word]  input frame (unpacked array [n_word-1:0])
// - in_valid   in   1                        input frame valid
// - in_ready   out  1                        input frame accepted when in_valid&in_ready
// - out        out  [word_size-1:0][n_word]  aligned frame (unpacked array [n_word-1:0])
// - out_valid  out  1                        out holds an unconsumed aligned frame
// - out_ready  in   1                        downstream accepts when out_valid&out_ready
// - frame_cnt  out  16                       aligned frames delivered since reset/sh_load, wraps 0xFFFF->0
// BEHAVIOUR
// - Stream word index w = f*n_word + j for input frame f, word j. Aligned frame k word j = stream word
//   k*n_word + j + off, off = registered offset. With prev = last accepted frame, cur = frame being accepted:
//   out[j] = (j+off < n_word) ? prev[j+off] : cur[j+off-n_word].
// - Reset: state=EMPTY, off=0, prev=0, out=0, out_valid=0, frame_cnt=0; in_ready=1 after reset deasserts.
// - States: EMPTY (no history) -> PRIMED on first accepted frame (stored to prev, no output).
//   PRIMED: each accepted frame writes aligned frame to out, sets out_valid, prev<=cur.
// - in_ready = !sh_load && (state==EMPTY || !out_valid || out_ready). No combinational path in_valid->out.
// - Latency: aligned frame k registered on the clock edge accepting input frame k+1 (1 cycle after that handshake).
//   off=0 still uses prev path (out=prev), latency unchanged.
// - Output: out/out_valid hold stable while out_valid&!out_ready. Simultaneous consume+accept: new frame
//   loaded same edge, out_valid stays 1 (full throughput, one frame/cycle).
// - frame_cnt increments on every out handshake; wraps silently.
// - sh_load (priority over in_valid): off<=sh_val, state<=EMPTY, prev cleared, frame_cnt<=0; pending out/out_valid
//   retained and drained normally. Input not accepted that cycle. Back-to-back sh_load: last value wins.
// - sh_val >= n_word impossible (width-limited); all offsets 0..n_word-1 legal.
// - Async reset mid-stream: all state cleared immediately, partial history discarded; no spurious out_valid.
// STRUCTURE
// - Package barrelshift_pkg: typedef word_t (logic [word_size-1:0]), typedef enum {EMPTY, PRIMED} align_state_e,
//   localparam FRAME_CNT_W=16. Shared with the rotator side.
// - One sub-module: barrelunshift_window (combinational 2*n_word -> n_word window select by off, mux tree of
//   bit_shift levels, same bit-transposed slicing as the forward rotator). Top holds FSM, prev/out regs, handshake.
// TESTING (defaults: n_word=8, word_size=9; word value = stream index w)
// - Reset: rst_n low mid-stream -> out_valid=0, frame_cnt=0, out all 0 same cycle; in_ready=1 after release.
// - off=0, frames {0..7},{8..15},{16..23} back-to-back, out_ready=1 -> outputs {0..7},{8..15}; no output for frame 0 alone.
// - sh_load sh_val=3, same frames -> out={3..10} then {11..18}; out[0]=3, out[7]=10.
// - off=7, out_ready held 0 for 5 cycles -> out={7..14} stable, in_ready=0 after one pending frame; release -> full rate resumes, no loss/dup.
// - sh_load asserted with in_valid=1 and out_valid=1 -> in_ready=0, input not taken, pending out drains, next two frames re-prime.
// - Random off/backpressure vs reference model over 10k frames; frame_cnt after 65537 handshakes = 1.

Source files
------------

// File: rtl/barrelshift_pkg.sv
// Shared types for the barrel rotator and its receive-side unshifter.
// Word type, alignment FSM states and frame counter width.
package barrelshift_pkg;

   localparam int BIT_SHIFT   = 3;
   localparam int N_WORD      = 2 ** BIT_SHIFT;
   localparam int WORD_SIZE   = 9;
   localparam int FRAME_CNT_W = 16;

   typedef logic [WORD_SIZE-1:0] word_t;

   typedef enum logic {
      EMPTY,
      PRIMED
   } align_state_e;

endpackage

// File: rtl/barrelunshift_window.sv
// Selects n_word consecutive words out of {cur, prev} starting at off.
// Log-depth mux tree: level l shifts the window down by 2**l words.
module barrelunshift_window
   import barrelshift_pkg::*;
#(
   parameter int bit_shift = BIT_SHIFT,
   parameter int n_word    = 2 ** bit_shift,
   parameter int word_size = WORD_SIZE
) (
   input  logic [bit_shift-1:0] off,
   input  logic [word_size-1:0] prev [n_word],
   input  logic [word_size-1:0] cur  [n_word],
   output logic [word_size-1:0] win  [n_word]
);

   localparam int W2 = 2 * n_word;

   logic [word_size-1:0] lvl [bit_shift+1][W2];

   for (genvar i = 0; i < W2; i++) begin : g_src
      if (i < n_word) begin : g_prev
         assign lvl[0][i] = prev[i];
      end else begin : g_cur
         assign lvl[0][i] = cur[i-n_word];
      end
   end

   // Words shifted in past the top of the 2*n_word window are never selected.
   for (genvar l = 0; l < bit_shift; l++) begin : g_lvl
      for (genvar i = 0; i < W2; i++) begin : g_pos
         if (i + (2 ** l) < W2) begin : g_in
            assign lvl[l+1][i] = off[l] ? lvl[l][i+(2**l)]
                                        : lvl[l][i];
         end else begin : g_top
            assign lvl[l+1][i] = off[l] ? '0 : lvl[l][i];
         end
      end
   end

   for (genvar j = 0; j < n_word; j++) begin : g_out
      assign win[j] = lvl[bit_shift][j];
   end

endmodule

// File: rtl/barrelunshift_stream.sv
// Realigns a rotated n_word-word frame stream across frame boundaries.
// Holds one frame of history; registered output with valid/ready.
module barrelunshift_stream
   import barrelshift_pkg::*;
#(
   parameter int bit_shift = BIT_SHIFT,
   parameter int n_word    = 2 ** bit_shift,
   parameter int word_size = WORD_SIZE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sh_load,
   input  logic [bit_shift-1:0]   sh_val,
   input  logic [word_size-1:0]   in [n_word],
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [word_size-1:0]   out [n_word],
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   align_state_e         state_q;
   align_state_e         state_d;
   logic [bit_shift-1:0] off_q;
   logic [word_size-1:0] prev_q [n_word];
   logic [word_size-1:0] win    [n_word];

   logic accept;
   logic out_fire;
   logic load_out;

   barrelunshift_window #(
      .bit_shift (bit_shift),
      .n_word    (n_word),
      .word_size (word_size)
   ) u_window (
      .off  (off_q),
      .prev (prev_q),
      .cur  (in),
      .win  (win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sh_load) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = PRIMED;
      end
   end

   // Ready depends only on registered state and sh_load, never on in_valid.
   always_comb begin
      in_ready = !sh_load &&
                 (state_q == EMPTY || !out_valid || out_ready);
      accept   = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      load_out = accept && (state_q == PRIMED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_q     <= '0;
         out_valid <= 1'b0;
         frame_cnt <= '0;
         for (int i = 0; i < n_word; i++) begin
            prev_q[i] <= '0;
            out[i]    <= '0;
         end
      end else begin
         if (load_out) begin
            out       <= win;
            out_valid <= 1'b1;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         if (sh_load) begin
            off_q     <= sh_val;
            frame_cnt <= '0;
            for (int i = 0; i < n_word; i++) begin
               prev_q[i] <= '0;
            end
         end else begin
            if (out_fire) begin
               frame_cnt <= frame_cnt + 1'b1;
            end
            if (accept) begin
               prev_q <= in;
            end
         end
      end
   end

endmodule

// File: tb/tb_barrelunshift_stream.sv
// Bench for barrelunshift_stream: scoreboard of aligned frames,
// per-cycle handshake model, directed scenarios and random traffic.
module tb_barrelunshift_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sh_load;
   logic [2:0]  sh_val;
   logic [8:0]  din  [8];
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  dout [8];
   logic        out_valid;
   logic        out_ready;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0]  m_prev [8];
   bit          m_empty;
   bit          m_ov;
   logic [2:0]  m_off;
   logic [15:0] m_cnt;
   logic [71:0] sb [$];

   bit last_acc;
   bit last_fire;

   barrelunshift_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sh_load   (sh_load),
      .sh_val    (sh_val),
      .in        (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] flat(input logic [8:0] a [8]);
      logic [71:0] r;
      for (int j = 0; j < 8; j++) r[j*9 +: 9] = a[j];
      return r;
   endfunction

   function automatic logic [71:0] seq(input int base);
      logic [71:0] r;
      for (int j = 0; j < 8; j++) r[j*9 +: 9] = 9'((base + j) & 'h1ff);
      return r;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < 8; j++) m_prev[j] = '0;
      m_empty = 1;
      m_ov    = 0;
      m_off   = '0;
      m_cnt   = '0;
      sb.delete();
   endtask

   task automatic set_frame(input int base);
      for (int j = 0; j < 8; j++) din[j] = 9'((base + j) & 'h1ff);
   endtask

   // Called in the low clock phase with inputs already driven.
   task automatic tick();
      logic        exp_rdy;
      logic [71:0] e;
      logic [71:0] got;
      bit          push;
      int          k;
      #1;
      exp_rdy = !sh_load && (m_empty || !m_ov || out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL in_ready: got %b want %b t=%0t", in_ready, exp_rdy, $time);
      end
      n_vec++;
      if (out_valid !== m_ov) begin
         n_err++;
         $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_ov, $time);
      end
      n_vec++;
      if (frame_cnt !== m_cnt) begin
         n_err++;
         $display("FAIL frame_cnt: got %0d want %0d t=%0t", frame_cnt, m_cnt, $time);
      end
      last_fire = out_valid && out_ready;
      last_acc  = in_valid && in_ready;
      if (last_fire) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL out_extra: got frame %h want none t=%0t", flat(dout), $time);
         end else begin
            e   = sb.pop_front();
            got = flat(dout);
            if (got !== e) begin
               n_err++;
               $display("FAIL out_data: got %h want %h t=%0t", got, e, $time);
            end
         end
      end
      if (sh_load) begin
         m_off   = sh_val;
         m_empty = 1;
         m_cnt   = '0;
         for (int j = 0; j < 8; j++) m_prev[j] = '0;
         if (last_fire) m_ov = 0;
      end else begin
         if (last_fire) m_cnt = m_cnt + 16'd1;
         push = 0;
         if (last_acc) begin
            if (!m_empty) begin
               for (int j = 0; j < 8; j++) begin
                  k = j + int'(m_off);
                  e[j*9 +: 9] = (k < 8) ? m_prev[k] : din[k-8];
               end
               sb.push_back(e);
               push = 1;
            end
            m_prev  = din;
            m_empty = 0;
         end
         if (push) m_ov = 1;
         else if (last_fire) m_ov = 0;
      end
      @(negedge clk);
   endtask

   task automatic send(input int base);
      int n;
      in_valid = 1;
      set_frame(base);
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 100);
      if (!last_acc) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got no accept want accept base=%0d", base);
      end
      in_valid = 0;
   endtask

   task automatic do_shload(input logic [2:0] v);
      sh_load = 1;
      sh_val  = v;
      tick();
      sh_load = 0;
   endtask

   task automatic drain();
      in_valid  = 0;
      out_ready = 1;
      repeat (3) tick();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic check_reset_outs(input string tag);
      n_vec++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'd0 || flat(dout) !== 72'd0) begin
         n_err++;
         $display("FAIL %s: got ov=%b cnt=%0d out=%h want 0/0/0",
                  tag, out_valid, frame_cnt, flat(dout));
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_reset_outs("reset_state");
      rst_n = 1;
      @(negedge clk);
      tick();
      out_ready = 1;
      send(0);
      send(8);
      #2;
      rst_n = 0;
      #1;
      check_reset_outs("reset_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_reset: got %b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_off0();
      out_ready = 1;
      send(0);
      send(8);
      send(16);
      drain();
   endtask

   task automatic test_off3();
      do_shload(3'd3);
      out_ready = 1;
      send(0);
      send(8);
      n_vec++;
      if (dout[0] !== 9'd3 || dout[7] !== 9'd10) begin
         n_err++;
         $display("FAIL off3_ends: got %0d/%0d want 3/10", dout[0], dout[7]);
      end
      send(16);
      drain();
   endtask

   task automatic test_backpressure();
      do_shload(3'd7);
      out_ready = 0;
      send(0);
      send(8);
      in_valid = 1;
      set_frame(16);
      repeat (5) begin
         tick();
         n_vec++;
         if (flat(dout) !== seq(7) || last_acc) begin
            n_err++;
            $display("FAIL stall_hold: got %h acc=%b want %h acc=0",
                     flat(dout), last_acc, seq(7));
         end
      end
      out_ready = 1;
      send(16);
      send(24);
      send(32);
      drain();
   endtask

   task automatic test_shload_pending();
      do_shload(3'd2);
      out_ready = 0;
      send(0);
      send(8);
      in_valid = 1;
      set_frame(16);
      sh_load  = 1;
      sh_val   = 3'd5;
      tick();
      sh_load = 0;
      n_vec++;
      if (last_acc || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL shload_block: got acc=%b ov=%b want acc=0 ov=1",
                  last_acc, out_valid);
      end
      out_ready = 1;
      send(16);
      send(24);
      send(32);
      drain();
   endtask

   task automatic test_random();
      int  frames;
      int  cyc;
      bit  hold;
      frames = 0;
      cyc    = 0;
      hold   = 0;
      while (frames < 10000 && cyc < 40000) begin
         sh_load = ($urandom % 400) == 0;
         sh_val  = 3'($urandom);
         if (!hold) begin
            for (int j = 0; j < 8; j++) din[j] = 9'($urandom);
            hold = 1;
         end
         in_valid  = ($urandom % 8) != 0;
         out_ready = ($urandom % 8) != 0;
         tick();
         if (last_acc) begin
            frames++;
            hold = 0;
         end
         cyc++;
      end
      sh_load = 0;
      n_vec++;
      if (frames < 10000) begin
         n_err++;
         $display("FAIL random_timeout: got %0d frames want 10000", frames);
      end
      drain();
   endtask

   task automatic test_wrap();
      int hs;
      int cyc;
      int w;
      do_shload(3'd4);
      out_ready = 1;
      in_valid  = 1;
      hs  = 0;
      cyc = 0;
      w   = 0;
      set_frame(0);
      while (hs < 65537 && cyc < 70000) begin
         tick();
         if (last_fire) hs++;
         if (last_acc) begin
            w++;
            set_frame(w * 8);
         end
         cyc++;
      end
      in_valid  = 0;
      out_ready = 0;
      #1;
      n_vec++;
      if (frame_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL cnt_wrap: got %0d want 1 hs=%0d", frame_cnt, hs);
      end
      @(negedge clk);
      drain();
   endtask

   initial begin
      rst_n     = 0;
      sh_load   = 0;
      sh_val    = '0;
      in_valid  = 0;
      out_ready = 0;
      set_frame(0);
      test_reset();
      test_off0();
      test_off3();
      test_backpressure();
      test_shload_pending();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
